ram_responder: RTL
==================

# ram_responder

Word-addressed synchronous RAM that answers the MiniSRC control unit's Read/Write strobes with a wait-stated, handshaked access. It sits between the MAR/MDR registers and the MDR input mux. It samples the address from MAR and write data from MDR, and returns read data on Mdatain. It tells the control unit when the access is done so the FSM can leave its memory wait state.

## Interface
- ADDR_WIDTH, 9: number of word-address bits used; depth = 2^ADDR_WIDTH words (512).
- DATA_WIDTH, 32: word width.
- WAIT_STATES, 2: extra cycles inserted before each access completes; legal range 0..15.
- INIT_FILE, "": hex image loaded into the array at elaboration; empty string means the array is left uninitialised.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Read  in  1  level read strobe from the control unit.
- Write  in  1  level write strobe from the control unit.
- MAR_Data  in  32  address; only bits [ADDR_WIDTH-1:0] are used, upper bits are ignored.
- MDR_Data  in  DATA_WIDTH  write data.
- Mdatain  out  DATA_WIDTH  registered read data, routed to the MDR input mux.
- mem_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high while an accepted access is in progress.
- mem_err  out  1  one-cycle pulse on an illegal request.

## Operation
- The reset is synchronous and active-high. On reset:
  - state becomes IDLE, the wait counter is 0 and arm is 1;
  - Mdatain, mem_ready, mem_busy and mem_err are all 0;
  - array contents are not cleared.
- arm flag:
  - set at any edge where Read=0 and Write=0;
  - cleared when a request is accepted or rejected.
  - A strobe held high across several cycles therefore yields exactly one access.
- IDLE state:
  - A request exists when arm=1 and exactly one of Read or Write is 1.
  - On a request: latch the address, the write data and the op; load the counter with WAIT_STATES; set mem_busy=1; go to ACCESS.
  - If arm=1 and Read=1 and Write=1: no access, mem_err=1 for one cycle, arm cleared, stay in IDLE.
- ACCESS state:
  - If counter≠0, decrement it.
  - If counter=0, perform the access and go to RESP with mem_ready=1.
    - Write: array[addr] ← latched data.
    - Read: Mdatain ← array[addr].
- RESP state: lasts exactly one cycle with mem_ready=1 and mem_busy=1. At the next edge: go to IDLE, mem_ready=0, mem_busy=0.
- Strobe changes during ACCESS or RESP:
  - They do not alter the latched access.
  - Deasserting both strobes still sets arm.
  - A new request is accepted only from IDLE, so the earliest back-to-back acceptance is the edge after RESP.
- Mdatain behaviour:
  - Holds its value until the next completed read; writes do not change it.
  - A read of the address just written returns the new data.
- Array: single port, inferred as block RAM; synchronous write and registered read.

## Timing
- Acceptance edge E0. Access and mem_ready rise at edge E(WAIT_STATES+1). mem_ready falls at E(WAIT_STATES+2).
- Total occupancy is WAIT_STATES+2 cycles; WAIT_STATES=0 gives 2 cycles.
- Mdatain is valid in the same cycle mem_ready is high. The control unit asserts MDR_in with Read during that cycle.
- Throughput: one access every WAIT_STATES+3 cycles when the strobe drops for one cycle between accesses.
- Reset mid-operation (ACCESS or RESP):
  - The access is aborted; a pending write is not performed.
  - No mem_ready is issued; outputs take their reset values at that edge.
  - Mdatain is forced to 0.
- mem_err and mem_ready are never high in the same cycle.

## Test plan
- **Write then read (WAIT_STATES=2):**
  - Stimulus: Write, addr 0x0A5, data 0xDEADBEEF, held 1 cycle.
  - Required: mem_ready at E3, mem_busy high E0–E3.
  - Then, after 1 idle cycle: Read 0x0A5.
  - Required: Mdatain=0xDEADBEEF with mem_ready at E3.
- **Held strobe:**
  - Stimulus: Read held high for 10 cycles.
  - Required: exactly one mem_ready pulse, no second access.
  - Stimulus: drop Read 1 cycle, reassert.
  - Required: second pulse.
- **Illegal request:**
  - Stimulus: Read=Write=1 in IDLE.
  - Required: mem_err pulse next cycle, mem_busy stays 0, array and Mdatain unchanged.
- **Reset mid-write:**
  - Stimulus: Write 0x12345678 to addr 0x1FF (old value 0x0), reset asserted at E1.
  - Required: outputs 0. A later read of 0x1FF returns 0x0.
- **WAIT_STATES=0, preloaded INIT_FILE:**
  - Stimulus: Read addr 0x000 containing 0x00800075.
  - Required: mem_ready at E1, Mdatain=0x00800075.
- **Address truncation:**
  - Stimulus: Write 0xCAFEF00D with MAR_Data=0xFFFF_FE03, then Read MAR_Data=0x003.
  - Required: returns 0xCAFEF00D.

Source files
------------

// File: rtl/ram_responder.sv
// Word-addressed RAM answering MiniSRC Read/Write strobes with a wait-stated,
// handshaked access: one access per strobe assertion, ready/err as one-cycle pulses.
module ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           MAR_Data,
  input  logic [DATA_WIDTH-1:0] MDR_Data,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  arm_q, arm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_wr_q, op_wr_d;
  logic                  busy_d, ready_d, err_d;
  logic                  do_write_c, do_read_c;

  // Upper address bits are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^MAR_Data[31:ADDR_WIDTH];

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arm_d      = arm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    busy_d     = mem_busy;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    do_write_c = 1'b0;
    do_read_c  = 1'b0;

    if (!Read && !Write) arm_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (arm_q && (Read ^ Write)) begin
          addr_d  = MAR_Data[ADDR_WIDTH-1:0];
          wdata_d = MDR_Data;
          op_wr_d = Write;
          cnt_d   = CNT_W'(WAIT_STATES);
          busy_d  = 1'b1;
          arm_d   = 1'b0;
          state_d = ACCESS;
        end else if (arm_q && Read && Write) begin
          err_d = 1'b1;
          arm_d = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end else begin
          do_write_c = op_wr_q;
          do_read_c  = !op_wr_q;
          ready_d    = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arm_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      mem_ready <= ready_d;
      mem_busy  <= busy_d;
      mem_err   <= err_d;
      if (do_read_c) Mdatain <= mem[addr_q];
    end
  end

  // Array write port; a write pending at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (do_write_c && !reset) mem[addr_q] <= wdata_q;
  end

endmodule
